ring_router_fifo: RTL and testbench

Parametrised three-port ring router for the cardinal CMP ring, successor to the single-flit-buffered router. It sits at each ring node between the clockwise (cw) link, the counter-clockwise (ccw) link and the local processing element (pe). It adds per-input FIFOs of configurable depth, registered output slots, round-robin output arbitration, hop-count decrement on forwarding, and FIFO occupancy status. The polarity / virtual-channel scheme is replaced by FIFO buffering, so there is no polarity input.

---
 rtl/ring_router_fifo.sv | 243 ++++++++++++++++++++++++
 tb/tb_ring_router_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_router_fifo.sv
// Three-port ring router (cw/ccw/pe): per-input FIFOs, round-robin arbitration, one register slot per output.
// Latency 2 cycles pass-through; ready drops when an input FIFO is full and a slot holds while its ro=0.

module rrf_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW_W  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             pop_i,
  output logic             rdy_o,
  output logic             vld_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CW_W-1:0]  cnt_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW_W-1:0]  cnt_q, cnt_d;
  logic             do_push;

  // Ready is based on the current count only; a same-cycle pop does not reopen it.
  assign rdy_o   = !reset && (cnt_q != CW_W'(DEPTH));
  assign do_push = push_i && rdy_o;
  assign vld_o   = (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (pop_i)   rd_d = rd_q + PW'(1);
    if (do_push && !pop_i)      cnt_d = cnt_q + CW_W'(1);
    else if (!do_push && pop_i) cnt_d = cnt_q - CW_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= dat_i;
  end
endmodule

module rrf_arb (
  input  logic clk,
  input  logic reset,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic ld_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);
  // ptr_q = 0 favours requester a (the ring input); flips to the loser after every grant.
  logic ptr_q, ptr_d;

  assign gnt_a_o = ld_i && req_a_i && (!req_b_i || !ptr_q);
  assign gnt_b_o = ld_i && req_b_i && (!req_a_i || ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_a_o)      ptr_d = 1'b1;
    else if (gnt_b_o) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
endmodule

module ring_router_fifo #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 4,
  parameter int HOP_LSB = 48,
  parameter int HOP_W   = 8,
  parameter int DIR_BIT = 62,
  parameter int CW_W    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cwsi,
  input  logic             ccwsi,
  input  logic             pesi,
  output logic             cwri,
  output logic             ccwri,
  output logic             peri,
  input  logic [WIDTH-1:0] cwdi,
  input  logic [WIDTH-1:0] ccwdi,
  input  logic [WIDTH-1:0] pedi,
  output logic             cwso,
  output logic             ccwso,
  output logic             peso,
  input  logic             cwro,
  input  logic             ccwro,
  input  logic             pero,
  output logic [WIDTH-1:0] cwdo,
  output logic [WIDTH-1:0] ccwdo,
  output logic [WIDTH-1:0] pedo,
  output logic [CW_W-1:0]  cw_cnt,
  output logic [CW_W-1:0]  ccw_cnt,
  output logic [CW_W-1:0]  pe_cnt
);
  logic             cw_vld, ccw_vld, pe_vld;
  logic             cw_pop, ccw_pop, pe_pop;
  logic [WIDTH-1:0] cw_head, ccw_head, pe_head;
  logic [WIDTH-1:0] cw_fwd, ccw_fwd;
  logic [HOP_W-1:0] cw_hop, ccw_hop;

  rrf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW_W(CW_W)) u_fifo_cw (
    .clk(clk), .reset(reset), .push_i(cwsi), .dat_i(cwdi), .pop_i(cw_pop),
    .rdy_o(cwri), .vld_o(cw_vld), .head_o(cw_head), .cnt_o(cw_cnt)
  );
  rrf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW_W(CW_W)) u_fifo_ccw (
    .clk(clk), .reset(reset), .push_i(ccwsi), .dat_i(ccwdi), .pop_i(ccw_pop),
    .rdy_o(ccwri), .vld_o(ccw_vld), .head_o(ccw_head), .cnt_o(ccw_cnt)
  );
  rrf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW_W(CW_W)) u_fifo_pe (
    .clk(clk), .reset(reset), .push_i(pesi), .dat_i(pedi), .pop_i(pe_pop),
    .rdy_o(peri), .vld_o(pe_vld), .head_o(pe_head), .cnt_o(pe_cnt)
  );

  assign cw_hop  = cw_head[HOP_LSB +: HOP_W];
  assign ccw_hop = ccw_head[HOP_LSB +: HOP_W];

  // Ring-to-ring forwarding consumes one hop; ejected and injected flits pass untouched.
  always_comb begin
    cw_fwd  = cw_head;
    ccw_fwd = ccw_head;
    cw_fwd[HOP_LSB +: HOP_W]  = cw_hop - HOP_W'(1);
    ccw_fwd[HOP_LSB +: HOP_W] = ccw_hop - HOP_W'(1);
  end

  logic cw_so_q, cw_so_d, ccw_so_q, ccw_so_d, pe_so_q, pe_so_d;
  logic [WIDTH-1:0] cw_do_q, cw_do_d, ccw_do_q, ccw_do_d, pe_do_q, pe_do_d;
  logic cw_ld, ccw_ld, pe_ld;
  logic g_cw_cw, g_pe_cw, g_ccw_ccw, g_pe_ccw, g_cw_pe, g_ccw_pe;

  assign cw_ld  = !cw_so_q  || cwro;
  assign ccw_ld = !ccw_so_q || ccwro;
  assign pe_ld  = !pe_so_q  || pero;

  rrf_arb u_arb_cw (
    .clk(clk), .reset(reset),
    .req_a_i(cw_vld && (cw_hop != '0)), .req_b_i(pe_vld && !pe_head[DIR_BIT]),
    .ld_i(cw_ld), .gnt_a_o(g_cw_cw), .gnt_b_o(g_pe_cw)
  );
  rrf_arb u_arb_ccw (
    .clk(clk), .reset(reset),
    .req_a_i(ccw_vld && (ccw_hop != '0)), .req_b_i(pe_vld && pe_head[DIR_BIT]),
    .ld_i(ccw_ld), .gnt_a_o(g_ccw_ccw), .gnt_b_o(g_pe_ccw)
  );
  rrf_arb u_arb_pe (
    .clk(clk), .reset(reset),
    .req_a_i(cw_vld && (cw_hop == '0)), .req_b_i(ccw_vld && (ccw_hop == '0)),
    .ld_i(pe_ld), .gnt_a_o(g_cw_pe), .gnt_b_o(g_ccw_pe)
  );

  // Each head targets exactly one output, so at most one of each pair fires.
  assign cw_pop  = g_cw_cw   || g_cw_pe;
  assign ccw_pop = g_ccw_ccw || g_ccw_pe;
  assign pe_pop  = g_pe_cw   || g_pe_ccw;

  always_comb begin
    cw_so_d  = cw_so_q;
    cw_do_d  = cw_do_q;
    ccw_so_d = ccw_so_q;
    ccw_do_d = ccw_do_q;
    pe_so_d  = pe_so_q;
    pe_do_d  = pe_do_q;

    if (g_cw_cw) begin
      cw_so_d = 1'b1;
      cw_do_d = cw_fwd;
    end else if (g_pe_cw) begin
      cw_so_d = 1'b1;
      cw_do_d = pe_head;
    end else if (cwro) begin
      cw_so_d = 1'b0;
    end

    if (g_ccw_ccw) begin
      ccw_so_d = 1'b1;
      ccw_do_d = ccw_fwd;
    end else if (g_pe_ccw) begin
      ccw_so_d = 1'b1;
      ccw_do_d = pe_head;
    end else if (ccwro) begin
      ccw_so_d = 1'b0;
    end

    if (g_cw_pe) begin
      pe_so_d = 1'b1;
      pe_do_d = cw_head;
    end else if (g_ccw_pe) begin
      pe_so_d = 1'b1;
      pe_do_d = ccw_head;
    end else if (pero) begin
      pe_so_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw_so_q  <= 1'b0;
      ccw_so_q <= 1'b0;
      pe_so_q  <= 1'b0;
      cw_do_q  <= '0;
      ccw_do_q <= '0;
      pe_do_q  <= '0;
    end else begin
      cw_so_q  <= cw_so_d;
      ccw_so_q <= ccw_so_d;
      pe_so_q  <= pe_so_d;
      cw_do_q  <= cw_do_d;
      ccw_do_q <= ccw_do_d;
      pe_do_q  <= pe_do_d;
    end
  end

  assign cwso  = cw_so_q;
  assign ccwso = ccw_so_q;
  assign peso  = pe_so_q;
  assign cwdo  = cw_do_q;
  assign ccwdo = ccw_do_q;
  assign pedo  = pe_do_q;
endmodule

// File: tb/tb_ring_router_fifo.sv
// Bench for ring_router_fifo: queue-based reference model compared every cycle, plus directed literal checks.
module tb_ring_router_fifo;
  localparam int WIDTH = 64, DEPTH = 4, HOP_LSB = 48, HOP_W = 8, DIR_BIT = 62, CW_W = 3;
  typedef logic [63:0] flit_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic cwsi = 0, ccwsi = 0, pesi = 0, cwro = 1, ccwro = 1, pero = 1;
  logic cwri, ccwri, peri, cwso, ccwso, peso;
  flit_t cwdi = '0, ccwdi = '0, pedi = '0;
  flit_t cwdo, ccwdo, pedo;
  logic [CW_W-1:0] cw_cnt, ccw_cnt, pe_cnt;

  ring_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOP_LSB(HOP_LSB), .HOP_W(HOP_W),
                     .DIR_BIT(DIR_BIT), .CW_W(CW_W)) dut (
    .clk(clk), .reset(reset),
    .cwsi(cwsi), .ccwsi(ccwsi), .pesi(pesi),
    .cwri(cwri), .ccwri(ccwri), .peri(peri),
    .cwdi(cwdi), .ccwdi(ccwdi), .pedi(pedi),
    .cwso(cwso), .ccwso(ccwso), .peso(peso),
    .cwro(cwro), .ccwro(ccwro), .pero(pero),
    .cwdo(cwdo), .ccwdo(ccwdo), .pedo(pedo),
    .cw_cnt(cw_cnt), .ccw_cnt(ccw_cnt), .pe_cnt(pe_cnt)
  );

  // Model state; index 0 = cw, 1 = ccw, 2 = pe for outputs, pointers and senders.
  flit_t mq_cw[$], mq_ccw[$], mq_pe[$];
  bit    m_so[3];
  flit_t m_do[3];
  bit    m_fav_b[3];
  flit_t off_cw[$], off_ccw[$], off_pe[$];
  bit    hold[3];
  int    send_pct = 100;
  int    checks = 0, failures = 0;

  function automatic bit is_fwd(flit_t f);
    return f[HOP_LSB +: HOP_W] != 0;
  endfunction

  function automatic bit m_ri(int sz);
    return !reset && (sz != DEPTH);
  endfunction

  task automatic check64(input string name, input flit_t act, input flit_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check64("cwso", 64'(cwso), 64'(m_so[0]));
    check64("ccwso", 64'(ccwso), 64'(m_so[1]));
    check64("peso", 64'(peso), 64'(m_so[2]));
    check64("cwdo", cwdo, m_do[0]);
    check64("ccwdo", ccwdo, m_do[1]);
    check64("pedo", pedo, m_do[2]);
    check64("cwri", 64'(cwri), 64'(m_ri(mq_cw.size())));
    check64("ccwri", 64'(ccwri), 64'(m_ri(mq_ccw.size())));
    check64("peri", 64'(peri), 64'(m_ri(mq_pe.size())));
    check64("cw_cnt", 64'(cw_cnt), 64'(mq_cw.size()));
    check64("ccw_cnt", 64'(ccw_cnt), 64'(mq_ccw.size()));
    check64("pe_cnt", 64'(pe_cnt), 64'(mq_pe.size()));
  endtask

  // Drive one cycle from the negedge, advance the model at the posedge, compare at the next negedge.
  task automatic step();
    bit s[3], acc[3], hv[3], a[3], b[3], ro[3], ga[3], gb[3];
    flit_t h[3], da[3], db[3];
    s[0] = off_cw.size()  > 0 && (hold[0] || $urandom_range(99) < send_pct);
    s[1] = off_ccw.size() > 0 && (hold[1] || $urandom_range(99) < send_pct);
    s[2] = off_pe.size()  > 0 && (hold[2] || $urandom_range(99) < send_pct);
    cwsi = s[0]; ccwsi = s[1]; pesi = s[2];
    cwdi  = off_cw.size()  > 0 ? off_cw[0]  : '0;
    ccwdi = off_ccw.size() > 0 ? off_ccw[0] : '0;
    pedi  = off_pe.size()  > 0 ? off_pe[0]  : '0;
    acc[0] = s[0] && m_ri(mq_cw.size());
    acc[1] = s[1] && m_ri(mq_ccw.size());
    acc[2] = s[2] && m_ri(mq_pe.size());
    hv[0] = mq_cw.size() > 0;  h[0] = hv[0] ? mq_cw[0]  : '0;
    hv[1] = mq_ccw.size() > 0; h[1] = hv[1] ? mq_ccw[0] : '0;
    hv[2] = mq_pe.size() > 0;  h[2] = hv[2] ? mq_pe[0]  : '0;
    a[0] = hv[0] && is_fwd(h[0]);  b[0] = hv[2] && !h[2][DIR_BIT];
    a[1] = hv[1] && is_fwd(h[1]);  b[1] = hv[2] && h[2][DIR_BIT];
    a[2] = hv[0] && !is_fwd(h[0]); b[2] = hv[1] && !is_fwd(h[1]);
    da[0] = h[0] - (64'd1 << HOP_LSB); db[0] = h[2];
    da[1] = h[1] - (64'd1 << HOP_LSB); db[1] = h[2];
    da[2] = h[0];                      db[2] = h[1];
    ro[0] = cwro; ro[1] = ccwro; ro[2] = pero;
    for (int k = 0; k < 3; k++) begin
      bit ld;
      ld = !m_so[k] || ro[k];
      ga[k] = ld && a[k] && (!b[k] || !m_fav_b[k]);
      gb[k] = ld && b[k] && (!a[k] || m_fav_b[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (ga[k] || gb[k]) begin
        m_so[k] = 1'b1;
        m_do[k] = ga[k] ? da[k] : db[k];
        m_fav_b[k] = ga[k];
      end else if (ro[k]) begin
        m_so[k] = 1'b0;
      end
    end
    if (ga[0] || ga[2]) void'(mq_cw.pop_front());
    if (ga[1] || gb[2]) void'(mq_ccw.pop_front());
    if (gb[0] || gb[1]) void'(mq_pe.pop_front());
    if (acc[0]) mq_cw.push_back(off_cw.pop_front());
    if (acc[1]) mq_ccw.push_back(off_ccw.pop_front());
    if (acc[2]) mq_pe.push_back(off_pe.pop_front());
    for (int k = 0; k < 3; k++) hold[k] = s[k] && !acc[k];
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mq_cw.delete(); mq_ccw.delete(); mq_pe.delete();
    off_cw.delete(); off_ccw.delete(); off_pe.delete();
    for (int k = 0; k < 3; k++) begin
      m_so[k] = 0; m_do[k] = '0; m_fav_b[k] = 0; hold[k] = 0;
    end
    cwsi = 0; ccwsi = 0; pesi = 0;
    #1 compare_all();
    repeat (2) begin
      @(negedge clk);
      compare_all();
    end
    reset = 1'b0;
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic flush();
    int n;
    cwro = 1; ccwro = 1; pero = 1; send_pct = 100;
    n = 0;
    while ((off_cw.size() + off_ccw.size() + off_pe.size() + mq_cw.size() + mq_ccw.size() +
            mq_pe.size() + int'(m_so[0]) + int'(m_so[1]) + int'(m_so[2])) != 0 && n < 100) begin
      step();
      n++;
    end
    check64("flush_timeout", 64'(n >= 100), 64'd0);
  endtask

  function automatic flit_t rand_flit();
    flit_t f;
    f = {$urandom, $urandom};
    if ($urandom_range(2) == 0) f[HOP_LSB +: HOP_W] = '0;
    return f;
  endfunction

  initial begin
    int got;
    #2;
    do_reset();
    // Reset release state, pinned literally.
    check64("rst_cwso", 64'(cwso), 64'd0);
    check64("rst_peso", 64'(peso), 64'd0);
    check64("rst_cwdo", cwdo, 64'd0);
    check64("rst_pe_cnt", 64'(pe_cnt), 64'd0);
    check64("rst_ri", {61'd0, cwri, ccwri, peri}, 64'd7);

    // Contention on the pe output: starts with cw, then alternates.
    for (int i = 0; i < 6; i++) begin
      off_cw.push_back({8'hA1, 8'h00, 40'h0, 8'(i)});
      off_ccw.push_back({8'hB2, 8'h00, 40'h0, 8'(i)});
    end
    step();
    for (int j = 0; j < 4; j++) begin
      step();
      check64("arb_peso", 64'(peso), 64'd1);
      check64("arb_src", 64'(pedo[63:56]), (j % 2 == 0) ? 64'hA1 : 64'hB2);
    end
    flush();

    // Single-flit routing and hop handling.
    off_cw.push_back(64'h5A03_1122_3344_5566);
    step(); step();
    check64("fwd_cwso", 64'(cwso), 64'd1);
    check64("fwd_cwdo", cwdo, 64'h5A02_1122_3344_5566);
    check64("fwd_peso", 64'(peso), 64'd0);
    flush();
    off_cw.push_back(64'h5A00_1122_3344_5566);
    step(); step();
    check64("eject_peso", 64'(peso), 64'd1);
    check64("eject_pedo", pedo, 64'h5A00_1122_3344_5566);
    flush();
    off_pe.push_back(64'h4000_0000_0000_00AA);
    step(); step();
    check64("inj_ccwdo", ccwdo, 64'h4000_0000_0000_00AA);
    check64("inj_ccw_peso", 64'(peso), 64'd0);
    flush();
    off_pe.push_back(64'h0000_0000_0000_00BB);
    step(); step();
    check64("inj_cwdo", cwdo, 64'h0000_0000_0000_00BB);
    check64("inj_cw_peso", 64'(peso), 64'd0);
    flush();

    // Backpressure on the cw output.
    cwro = 0;
    for (int i = 0; i < 6; i++) off_cw.push_back(64'hC005_0000_0000_0000 | 64'(i));
    repeat (8) step();
    check64("bp_cwso", 64'(cwso), 64'd1);
    check64("bp_cwdo", cwdo, 64'hC004_0000_0000_0000);
    check64("bp_cnt", 64'(cw_cnt), 64'd4);
    check64("bp_cwri", 64'(cwri), 64'd0);
    cwro = 1;
    got = 0;
    for (int t = 0; t < 30 && got < 6; t++) begin
      if (cwso) begin
        check64("bp_order", cwdo, 64'hC004_0000_0000_0000 | 64'(got));
        got++;
      end
      step();
    end
    check64("bp_count", 64'(got), 64'd6);
    flush();

    // Reset while flits are buffered.
    cwro = 0;
    for (int i = 0; i < 4; i++) off_cw.push_back(64'h3305_0000_0000_0000 | 64'(i));
    repeat (6) step();
    check64("mid_pre_cnt", 64'(cw_cnt), 64'd3);
    reset = 1'b1;
    #1;
    check64("mid_cwso", 64'(cwso), 64'd0);
    check64("mid_cnt", 64'(cw_cnt), 64'd0);
    do_reset();
    cwro = 1;
    off_cw.push_back(64'h7701_0000_0000_0001);
    step(); step();
    check64("post_cwso", 64'(cwso), 64'd1);
    check64("post_cwdo", cwdo, 64'h7700_0000_0000_0001);
    flush();

    // Randomised traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      if (off_cw.size()  < 3 && $urandom_range(1) == 0) off_cw.push_back(rand_flit());
      if (off_ccw.size() < 3 && $urandom_range(1) == 0) off_ccw.push_back(rand_flit());
      if (off_pe.size()  < 3 && $urandom_range(1) == 0) off_pe.push_back(rand_flit());
      cwro  = $urandom_range(99) < 75;
      ccwro = $urandom_range(99) < 75;
      pero  = $urandom_range(99) < 60;
      send_pct = 70;
      step();
    end
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
